// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/ack data-memory handshake.
// A memory access latches its address, data and direction, then holds the
// pipeline with Stall until mem_ack arrives or the wait counter times out.
// Non-memory instructions pass straight through with no added latency.
module mem_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        PCS,
    input  logic        HALT,
    input  logic [15:0] ALU_Out,
    input  logic [15:0] StoreData,
    input  logic [15:0] PC_Inc,
    input  logic [3:0]  Rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        Stall,
    output logic        RegWrite_Out,
    output logic        MemtoReg_Out,
    output logic        PCS_Out,
    output logic        HALT_Out,
    output logic [15:0] ALU_Out_Out,
    output logic [15:0] DataMem_Out,
    output logic [15:0] PC_Inc_Out,
    output logic [3:0]  Rd_Out,
    output logic        MemErr
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_err_q, mem_err_d;

    logic access;
    logic busy;
    logic timeout_hit;

    assign access      = MemRead | MemWrite;
    assign busy        = (state_q == BUSY);
    assign timeout_hit = busy & ~mem_ack & (cnt_q == CNT_LAST);

    // State register; reset drops any in-flight access immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on access, finish on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access)                state_d = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the request, count waits, capture data, flag errors.
    always_comb begin
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_err_d   = mem_err_q;
        if (!busy) begin
            if (access) begin
                // A simultaneous read+write request is treated as a write.
                mem_we_d    = MemWrite;
                mem_addr_d  = ALU_Out;
                mem_wdata_d = StoreData;
                cnt_d       = 8'd0;
            end
        end else if (mem_ack) begin
            rdata_d = mem_rdata;
        end else if (timeout_hit) begin
            mem_err_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            cnt_q       <= 8'd0;
            rdata_q     <= 16'd0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Outputs: stall, bubble insertion, forced halt on timeout, read-data bypass.
    always_comb begin
        Stall        = busy ? (~mem_ack & ~timeout_hit) : access;
        RegWrite_Out = ~Stall & RegWrite;
        HALT_Out     = timeout_hit | (~Stall & HALT);
        DataMem_Out  = (busy & mem_ack) ? mem_rdata : rdata_q;
    end

    assign mem_req      = busy;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign MemErr       = mem_err_q;
    assign MemtoReg_Out = MemtoReg;
    assign PCS_Out      = PCS;
    assign ALU_Out_Out  = ALU_Out;
    assign PC_Inc_Out   = PC_Inc;
    assign Rd_Out       = Rd;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic against an
// access-level reference model of the MEM stage.
module tb_mem_stage;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, RegWrite, MemtoReg, PCS, HALT;
    logic [15:0] ALU_Out, StoreData, PC_Inc;
    logic [3:0]  Rd;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        Stall, RegWrite_Out, MemtoReg_Out, PCS_Out, HALT_Out;
    logic [15:0] ALU_Out_Out, DataMem_Out, PC_Inc_Out;
    logic [3:0]  Rd_Out;
    logic        MemErr;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .PCS(PCS), .HALT(HALT),
        .ALU_Out(ALU_Out), .StoreData(StoreData), .PC_Inc(PC_Inc), .Rd(Rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Stall(Stall), .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
        .PCS_Out(PCS_Out), .HALT_Out(HALT_Out), .ALU_Out_Out(ALU_Out_Out),
        .DataMem_Out(DataMem_Out), .PC_Inc_Out(PC_Inc_Out), .Rd_Out(Rd_Out),
        .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding access, how long it has waited, last data read.
    bit          m_busy;
    int          m_waited;
    logic [15:0] m_addr, m_wdata, m_rdata;
    bit          m_we, m_err;

    // Output snapshot from the most recent sample point.
    logic        s_stall, s_req, s_we, s_regwr, s_halt, s_err;
    logic [15:0] s_addr, s_wdata, s_dout;
    logic [3:0]  s_rd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_waited = 0;
        m_addr   = 16'd0;
        m_wdata  = 16'd0;
        m_rdata  = 16'd0;
        m_we     = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock: compare every output at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit          acc, done, tout, stl;
        logic [15:0] dout;
        if (!rst_n) model_reset();
        @(negedge clk);
        acc  = MemRead | MemWrite;
        done = m_busy && mem_ack;
        tout = m_busy && !mem_ack && (m_waited == TIMEOUT - 1);
        stl  = m_busy ? !(done || tout) : acc;
        dout = done ? mem_rdata : m_rdata;
        s_stall = Stall;   s_req = mem_req;     s_we = mem_we;
        s_regwr = RegWrite_Out; s_halt = HALT_Out; s_err = MemErr;
        s_addr = mem_addr; s_wdata = mem_wdata; s_dout = DataMem_Out; s_rd = Rd_Out;
        chk("stall",    16'(Stall),        16'(stl));
        chk("mem_req",  16'(mem_req),      16'(m_busy));
        chk("mem_we",   16'(mem_we),       16'(m_we));
        chk("mem_addr", mem_addr,          m_addr);
        chk("mem_wdata", mem_wdata,        m_wdata);
        chk("dmem_out", DataMem_Out,       dout);
        chk("regwr_out", 16'(RegWrite_Out), 16'(!stl && RegWrite));
        chk("halt_out", 16'(HALT_Out),     16'(tout || (!stl && HALT)));
        chk("memerr",   16'(MemErr),       16'(m_err));
        chk("memtoreg_out", 16'(MemtoReg_Out), 16'(MemtoReg));
        chk("pcs_out",  16'(PCS_Out),      16'(PCS));
        chk("alu_out",  ALU_Out_Out,       ALU_Out);
        chk("pcinc_out", PC_Inc_Out,       PC_Inc);
        chk("rd_out",   16'(Rd_Out),       16'(Rd));
        @(posedge clk);
        if (rst_n) begin
            if (!m_busy) begin
                if (acc) begin
                    m_busy   = 1'b1;
                    m_waited = 0;
                    m_addr   = ALU_Out;
                    m_wdata  = StoreData;
                    m_we     = MemWrite;
                end
            end else if (done) begin
                m_busy  = 1'b0;
                m_rdata = mem_rdata;
            end else if (tout) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic quiet_inputs();
        MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0; PCS = 0; HALT = 0;
        ALU_Out = 16'd0; StoreData = 16'd0; PC_Inc = 16'd0; Rd = 4'd0;
        mem_ack = 0; mem_rdata = 16'd0;
    endtask

    initial begin
        int  nst, nbusy;
        bit  got, dead;

        rst_n = 1'b0;
        quiet_inputs();
        model_reset();

        // Reset state
        repeat (2) cycle();
        chk("rst_req", 16'(s_req), 16'd0);
        chk("rst_err", 16'(s_err), 16'd0);
        chk("rst_dout", s_dout, 16'd0);
        chk("rst_addr", s_addr, 16'd0);
        $display("TXN reset: req=%0b err=%0b dout=%h", s_req, s_err, s_dout);
        rst_n = 1'b1;
        cycle();

        // ALU op without memory access passes in the same cycle
        RegWrite = 1; Rd = 4'h5; ALU_Out = 16'h1111; PC_Inc = 16'h0102;
        cycle();
        chk("alu_stall", 16'(s_stall), 16'd0);
        chk("alu_regwr", 16'(s_regwr), 16'd1);
        chk("alu_rd", 16'(s_rd), 16'h0005);
        $display("TXN alu: stall=%0b regwr=%0b rd=%h", s_stall, s_regwr, s_rd);

        // Load, ack three cycles after mem_req
        quiet_inputs();
        MemRead = 1; RegWrite = 1; MemtoReg = 1; ALU_Out = 16'h0040;
        nst = 0; got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            mem_ack   = m_busy && (m_waited == 3);
            mem_rdata = mem_ack ? 16'hBEEF : 16'h0BAD;
            cycle();
            if (s_stall) nst++;
            else begin
                got = 1;
                chk("load_dout", s_dout, 16'hBEEF);
                chk("load_regwr", 16'(s_regwr), 16'd1);
                chk("load_addr", s_addr, 16'h0040);
            end
        end
        chk("load_done", 16'(got), 16'd1);
        chk("load_stalls", 16'(nst), 16'd4);
        quiet_inputs();
        cycle();
        chk("load_rdata_q", s_dout, 16'hBEEF);
        $display("TXN load: stalls=%0d dout=%h", nst, s_dout);

        // Store: latched request stays stable, no register write while stalled
        MemWrite = 1; RegWrite = 1; ALU_Out = 16'h0010; StoreData = 16'h1234;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            mem_ack   = m_busy && (m_waited == 2);
            mem_rdata = 16'h5555;
            if (m_busy) begin
                ALU_Out = 16'($urandom); StoreData = 16'($urandom); MemWrite = 0;
            end
            cycle();
            if (s_req) begin
                chk("store_we", 16'(s_we), 16'd1);
                chk("store_addr", s_addr, 16'h0010);
                chk("store_wdata", s_wdata, 16'h1234);
            end
            if (s_stall) chk("store_regwr", 16'(s_regwr), 16'd0);
            else got = 1;
        end
        chk("store_done", 16'(got), 16'd1);
        $display("TXN store: addr=%h wdata=%h", s_addr, s_wdata);
        quiet_inputs();
        cycle();

        // Read and write together is a write; stray ack in IDLE is ignored
        MemRead = 1; MemWrite = 1; ALU_Out = 16'h0022; StoreData = 16'h4321;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            mem_ack   = m_busy;
            mem_rdata = 16'h7777;
            cycle();
            if (s_req) chk("rw_we", 16'(s_we), 16'd1);
            if (!s_stall) got = 1;
        end
        quiet_inputs();
        mem_ack = 1; mem_rdata = 16'hDEAD;
        cycle();
        chk("stray_ack_dout", s_dout, 16'h7777);
        mem_ack = 0;
        cycle();
        chk("stray_ack_keep", s_dout, 16'h7777);
        $display("TXN rw: we=%0b dout=%h", s_we, s_dout);

        // Reset in the middle of an access
        MemRead = 1; ALU_Out = 16'h0030;
        cycle();
        MemRead = 0;
        cycle();
        rst_n = 1'b0;
        cycle();
        chk("rst_busy_req", 16'(s_req), 16'd0);
        chk("rst_busy_dout", s_dout, 16'd0);
        rst_n = 1'b1;
        mem_ack = 1; mem_rdata = 16'hAAAA;
        cycle();
        chk("late_ack_dout", s_dout, 16'd0);
        mem_ack = 0;
        cycle();
        chk("late_ack_keep", s_dout, 16'd0);
        $display("TXN reset_busy: req=%0b dout=%h", s_req, s_dout);

        // Load that is never acknowledged times out
        quiet_inputs();
        MemRead = 1; RegWrite = 1; ALU_Out = 16'h0050;
        nbusy = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            cycle();
            MemRead = 0;
            if (s_req) nbusy++;
            if (s_halt) begin
                got = 1;
                chk("tout_stall", 16'(s_stall), 16'd0);
            end
        end
        chk("tout_seen", 16'(got), 16'd1);
        chk("tout_busy_cycles", 16'(nbusy), 16'(TIMEOUT));
        quiet_inputs();
        cycle();
        chk("tout_err", 16'(s_err), 16'd1);
        chk("tout_halt_once", 16'(s_halt), 16'd0);
        repeat (5) cycle();
        chk("tout_err_sticky", 16'(s_err), 16'd1);
        $display("TXN timeout: busy=%0d err=%0b", nbusy, s_err);

        // Randomized traffic, including dead accesses and occasional resets
        dead = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_busy) dead = ($urandom_range(0, 39) == 0);
            MemRead   = ($urandom_range(0, 2) == 0);
            MemWrite  = ($urandom_range(0, 2) == 0);
            RegWrite  = 1'($urandom);
            MemtoReg  = 1'($urandom);
            PCS       = 1'($urandom);
            HALT      = ($urandom_range(0, 9) == 0);
            ALU_Out   = 16'($urandom);
            StoreData = 16'($urandom);
            PC_Inc    = 16'($urandom);
            Rd        = 4'($urandom);
            mem_rdata = 16'($urandom);
            mem_ack   = m_busy ? (!dead && $urandom_range(0, 2) == 0)
                               : ($urandom_range(0, 7) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        $display("TXN random: 3000 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
